trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter: MTVAL_EN, 1, 1 = sequence includes the mtval write state; 0 = that state is skipped.
REQ-002 CLK  input  1  clock; all state changes on posedge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 MEM_WAIT  input  1  pipeline stall; sequencer holds its state while high.
REQ-005 TRAP_EN  input  1  trap request from the trap unit.
REQ-006 TRAP_PC  input  32  PC of the trapping instruction.
REQ-007 TRAP_CODE  input  32  mcause value; bit31 = interrupt.
REQ-008 TRAP_JMP_TO  input  32  handler address.
REQ-009 MRET_EN  input  1  mret retiring.
REQ-010 MEPC_IN  input  32  current mepc CSR value.
REQ-011 MSTATUS_IN  input  32  current mstatus CSR value.
REQ-012 CSR_W_EN  output  1  CSR write strobe.
REQ-013 CSR_W_ADDR  output  12  CSR write address.
REQ-014 CSR_W_DATA  output  32  CSR write data.
REQ-015 FLUSH  output  1  pipeline flush request.
REQ-016 JMP_EN  output  1  fetch redirect strobe.
REQ-017 JMP_TO  output  32  fetch redirect target.
REQ-018 BUSY  output  1  sequence in progress; new requests ignored.
REQ-019 INT_ALLOW  output  1  interrupts may be taken.

Function
REQ-020 States SHALL be IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, R_MSTATUS, JUMP.
REQ-021 In IDLE with MEM_WAIT=0, TRAP_EN=1 SHALL latch TRAP_PC, TRAP_CODE, TRAP_JMP_TO and MSTATUS_IN, and go to T_MEPC.
REQ-022 In IDLE with MEM_WAIT=0, TRAP_EN=0 and MRET_EN=1 SHALL latch MEPC_IN and MSTATUS_IN, and go to R_MSTATUS.
REQ-023 TRAP_EN SHALL win over MRET_EN when both are high in the same cycle.
REQ-024 Trap path SHALL be T_MEPC -> T_MCAUSE -> T_MTVAL -> T_MSTATUS -> JUMP -> IDLE, one state per non-stalled cycle; T_MTVAL SHALL be skipped when MTVAL_EN=0.
REQ-025 Return path SHALL be R_MSTATUS -> JUMP -> IDLE.
REQ-026 T_MEPC SHALL write addr 0x341 with data {latched PC[31:2], 2'b00}.
REQ-027 T_MCAUSE SHALL write addr 0x342 with data = latched code.
REQ-028 T_MTVAL SHALL write addr 0x343 with data 32'h0.
REQ-029 T_MSTATUS SHALL write addr 0x300 with the latched mstatus modified as: bit7 (MPIE) = old bit3, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11; all other bits unchanged.
REQ-030 R_MSTATUS SHALL write addr 0x300 with the latched mstatus modified as: bit3 = old bit7, bit7 = 1, bits12:11 = 2'b11; all other bits unchanged.
REQ-031 JUMP SHALL assert JMP_EN=1 for exactly one cycle, with JMP_TO = latched TRAP_JMP_TO (trap) or latched MEPC_IN with bits[1:0] cleared (mret).
REQ-032 Outputs SHALL be decoded from the current state and latched registers, with no extra register stage.
REQ-033 With MTVAL_EN=1, a trap accepted at edge N SHALL give the mepc write in cycle N+1 and JMP_EN in cycle N+5.
REQ-034 An mret accepted at edge N SHALL give JMP_EN in cycle N+2.
REQ-035 FLUSH and BUSY SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-036 CSR_W_EN SHALL be 1 only in the write states.
REQ-037 CSR_W_ADDR, CSR_W_DATA and JMP_TO SHALL be 0 when their strobe is low.
REQ-038 While MEM_WAIT=1, the state and latches SHALL hold, CSR_W_EN and JMP_EN SHALL be forced 0, and FLUSH and BUSY SHALL keep their state-decoded value.
REQ-039 TRAP_EN and MRET_EN SHALL be ignored in any non-IDLE state; no queuing.
REQ-040 INT_ALLOW SHALL equal (state==IDLE) && MSTATUS_IN[3].

Reset
REQ-041 RST=1 at a posedge SHALL force IDLE and clear all latches, from any state including mid-sequence.
REQ-042 In the cycle after a reset edge, all outputs SHALL be 0 except INT_ALLOW, which follows REQ-040.
REQ-043 RST SHALL take priority over MEM_WAIT, TRAP_EN and MRET_EN.

Verification
REQ-044 Trap: TRAP_EN pulse, PC=0x0000_1006, CODE=0x0000_0002, JMP_TO=0x0000_0100, MSTATUS_IN=0x0000_0008 -> writes (0x341, 0x1004), (0x342, 0x2), (0x343, 0x0), (0x300, 0x1880) on consecutive cycles; then JMP_EN with JMP_TO=0x100; FLUSH high for 5 cycles.
REQ-045 mret: MRET_EN, MEPC_IN=0x0000_2002, MSTATUS_IN=0x0000_1880 -> write (0x300, 0x1888), then JMP_EN with JMP_TO=0x2000 in cycle N+2.
REQ-046 TRAP_EN and MRET_EN high in the same cycle -> trap path only; no R_MSTATUS write.
REQ-047 MEM_WAIT high for 3 cycles in T_MCAUSE -> no write strobes during the stall, FLUSH stays 1, mcause write on the first cycle after release, total latency +3.
REQ-048 RST in T_MSTATUS -> next cycle IDLE with BUSY=0, no mstatus write, no JMP_EN; a subsequent trap completes normally.
REQ-049 MTVAL_EN=0 with a second TRAP_EN while BUSY -> no 0x343 write, JMP_EN at N+4, second request ignored.

Source files
------------

// File: rtl/trap_sequencer.sv
// Sequences the CSR writes and fetch redirect for trap entry and mret.
// Outputs are decoded from the current state and the request latched in IDLE.
module trap_sequencer #(
  parameter bit MTVAL_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_WAIT,
  input  logic        TRAP_EN,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_JMP_TO,
  input  logic        MRET_EN,
  input  logic [31:0] MEPC_IN,
  input  logic [31:0] MSTATUS_IN,
  output logic        CSR_W_EN,
  output logic [11:0] CSR_W_ADDR,
  output logic [31:0] CSR_W_DATA,
  output logic        FLUSH,
  output logic        JMP_EN,
  output logic [31:0] JMP_TO,
  output logic        BUSY,
  output logic        INT_ALLOW
);

  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, R_MSTATUS, JUMP
  } state_t;

  state_t      state;
  logic [31:0] lat_pc;
  logic [31:0] lat_code;
  logic [31:0] lat_jmp;
  logic [31:0] lat_mstatus;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r         = m;
    r[7]      = m[3];
    r[3]      = 1'b0;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r         = m;
    r[3]      = m[7];
    r[7]      = 1'b1;
    r[12:11]  = 2'b11;
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      lat_pc      <= '0;
      lat_code    <= '0;
      lat_jmp     <= '0;
      lat_mstatus <= '0;
    end else if (!MEM_WAIT) begin
      case (state)
        IDLE: begin
          if (TRAP_EN) begin
            lat_pc      <= TRAP_PC;
            lat_code    <= TRAP_CODE;
            lat_jmp     <= TRAP_JMP_TO;
            lat_mstatus <= MSTATUS_IN;
            state       <= T_MEPC;
          end else if (MRET_EN) begin
            // mret target is stored already word-aligned
            lat_jmp     <= MEPC_IN & 32'hFFFF_FFFC;
            lat_mstatus <= MSTATUS_IN;
            state       <= R_MSTATUS;
          end
        end
        T_MEPC:    state <= T_MCAUSE;
        T_MCAUSE:  state <= MTVAL_EN ? T_MTVAL : T_MSTATUS;
        T_MTVAL:   state <= T_MSTATUS;
        T_MSTATUS: state <= JUMP;
        R_MSTATUS: state <= JUMP;
        JUMP:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    CSR_W_EN   = 1'b0;
    CSR_W_ADDR = '0;
    CSR_W_DATA = '0;
    JMP_EN     = 1'b0;
    JMP_TO     = '0;
    if (!MEM_WAIT) begin
      case (state)
        T_MEPC: begin
          CSR_W_EN   = 1'b1;
          CSR_W_ADDR = 12'h341;
          CSR_W_DATA = lat_pc & 32'hFFFF_FFFC;
        end
        T_MCAUSE: begin
          CSR_W_EN   = 1'b1;
          CSR_W_ADDR = 12'h342;
          CSR_W_DATA = lat_code;
        end
        T_MTVAL: begin
          CSR_W_EN   = 1'b1;
          CSR_W_ADDR = 12'h343;
        end
        T_MSTATUS: begin
          CSR_W_EN   = 1'b1;
          CSR_W_ADDR = 12'h300;
          CSR_W_DATA = trap_mstatus(lat_mstatus);
        end
        R_MSTATUS: begin
          CSR_W_EN   = 1'b1;
          CSR_W_ADDR = 12'h300;
          CSR_W_DATA = mret_mstatus(lat_mstatus);
        end
        JUMP: begin
          JMP_EN = 1'b1;
          JMP_TO = lat_jmp;
        end
        default: ;
      endcase
    end
  end

  assign FLUSH     = (state != IDLE);
  assign BUSY      = (state != IDLE);
  assign INT_ALLOW = (state == IDLE) && MSTATUS_IN[3];

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: instance a has the mtval state, instance b skips it.
module tb_trap_sequencer;
  logic        CLK = 1'b0;
  logic        RST, MEM_WAIT, TRAP_EN, MRET_EN;
  logic [31:0] TRAP_PC, TRAP_CODE, TRAP_JMP_TO, MEPC_IN, MSTATUS_IN;

  logic        a_wen, a_flush, a_jen, a_busy, a_int;
  logic [11:0] a_waddr;
  logic [31:0] a_wdata, a_jto;
  logic        b_wen, b_flush, b_jen, b_busy, b_int;
  logic [11:0] b_waddr;
  logic [31:0] b_wdata, b_jto;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  trap_sequencer #(.MTVAL_EN(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
    .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .MRET_EN(MRET_EN), .MEPC_IN(MEPC_IN),
    .MSTATUS_IN(MSTATUS_IN), .CSR_W_EN(a_wen), .CSR_W_ADDR(a_waddr), .CSR_W_DATA(a_wdata),
    .FLUSH(a_flush), .JMP_EN(a_jen), .JMP_TO(a_jto), .BUSY(a_busy), .INT_ALLOW(a_int));

  trap_sequencer #(.MTVAL_EN(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
    .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .MRET_EN(MRET_EN), .MEPC_IN(MEPC_IN),
    .MSTATUS_IN(MSTATUS_IN), .CSR_W_EN(b_wen), .CSR_W_ADDR(b_waddr), .CSR_W_DATA(b_wdata),
    .FLUSH(b_flush), .JMP_EN(b_jen), .JMP_TO(b_jto), .BUSY(b_busy), .INT_ALLOW(b_int));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every sequencing output of one instance (sel 0 = a, 1 = b).
  task automatic expect_out(input string tag, input bit sel, input logic wen,
                            input logic [11:0] addr, input logic [31:0] data,
                            input logic busy, input logic jen, input logic [31:0] jto);
    if (!sel) begin
      chk({tag, ".wen"}, 32'(a_wen), 32'(wen));
      chk({tag, ".addr"}, 32'(a_waddr), 32'(addr));
      chk({tag, ".data"}, a_wdata, data);
      chk({tag, ".flush"}, 32'(a_flush), 32'(busy));
      chk({tag, ".busy"}, 32'(a_busy), 32'(busy));
      chk({tag, ".jen"}, 32'(a_jen), 32'(jen));
      chk({tag, ".jto"}, a_jto, jto);
    end else begin
      chk({tag, ".wen"}, 32'(b_wen), 32'(wen));
      chk({tag, ".addr"}, 32'(b_waddr), 32'(addr));
      chk({tag, ".data"}, b_wdata, data);
      chk({tag, ".flush"}, 32'(b_flush), 32'(busy));
      chk({tag, ".busy"}, 32'(b_busy), 32'(busy));
      chk({tag, ".jen"}, 32'(b_jen), 32'(jen));
      chk({tag, ".jto"}, b_jto, jto);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; MEM_WAIT = 1'b0; TRAP_EN = 1'b0; MRET_EN = 1'b0;
    TRAP_PC = '0; TRAP_CODE = '0; TRAP_JMP_TO = '0; MEPC_IN = '0; MSTATUS_IN = '0;
    step();
    expect_out("rst", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);
    chk("rst.int0", 32'(a_int), 32'd0);
    MSTATUS_IN = 32'h8; #1;
    chk("rst.int1", 32'(a_int), 32'd1);
    RST = 1'b0;

    // Basic trap entry
    TRAP_EN = 1'b1; TRAP_PC = 32'h0000_1006; TRAP_CODE = 32'h2; TRAP_JMP_TO = 32'h100;
    step(); TRAP_EN = 1'b0;
    expect_out("trap.mepc", 0, 1, 12'h341, 32'h1004, 1, 0, 32'h0);
    chk("trap.int_busy", 32'(a_int), 32'd0);
    step(); expect_out("trap.mcause", 0, 1, 12'h342, 32'h2, 1, 0, 32'h0);
    step(); expect_out("trap.mtval", 0, 1, 12'h343, 32'h0, 1, 0, 32'h0);
    step(); expect_out("trap.mstatus", 0, 1, 12'h300, 32'h1880, 1, 0, 32'h0);
    step(); expect_out("trap.jump", 0, 0, 12'h0, 32'h0, 1, 1, 32'h100);
    step(); expect_out("trap.idle", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);
    chk("trap.int_idle", 32'(a_int), 32'd1);

    // mret
    MRET_EN = 1'b1; MEPC_IN = 32'h0000_2002; MSTATUS_IN = 32'h1880;
    step(); MRET_EN = 1'b0;
    expect_out("mret.mstatus", 0, 1, 12'h300, 32'h1888, 1, 0, 32'h0);
    step(); expect_out("mret.jump", 0, 0, 12'h0, 32'h0, 1, 1, 32'h2000);
    step(); expect_out("mret.idle", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);

    // Trap and mret together: trap wins
    TRAP_EN = 1'b1; MRET_EN = 1'b1; TRAP_PC = 32'h3000; TRAP_CODE = 32'h8000_0007;
    TRAP_JMP_TO = 32'h200; MSTATUS_IN = 32'h0;
    step(); TRAP_EN = 1'b0; MRET_EN = 1'b0;
    expect_out("both.mepc", 0, 1, 12'h341, 32'h3000, 1, 0, 32'h0);
    step(); expect_out("both.mcause", 0, 1, 12'h342, 32'h8000_0007, 1, 0, 32'h0);
    step(); expect_out("both.mtval", 0, 1, 12'h343, 32'h0, 1, 0, 32'h0);
    step(); expect_out("both.mstatus", 0, 1, 12'h300, 32'h1800, 1, 0, 32'h0);
    step(); expect_out("both.jump", 0, 0, 12'h0, 32'h0, 1, 1, 32'h200);
    step(); expect_out("both.idle", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);

    // Stall three cycles in T_MCAUSE, then one in JUMP
    TRAP_EN = 1'b1; TRAP_PC = 32'h1006; TRAP_CODE = 32'h2; TRAP_JMP_TO = 32'h100;
    MSTATUS_IN = 32'h8;
    step(); TRAP_EN = 1'b0;
    expect_out("stall.mepc", 0, 1, 12'h341, 32'h1004, 1, 0, 32'h0);
    step(); MEM_WAIT = 1'b1; #1;
    expect_out("stall.w1", 0, 0, 12'h0, 32'h0, 1, 0, 32'h0);
    step(); expect_out("stall.w2", 0, 0, 12'h0, 32'h0, 1, 0, 32'h0);
    step(); expect_out("stall.w3", 0, 0, 12'h0, 32'h0, 1, 0, 32'h0);
    step(); MEM_WAIT = 1'b0; #1;
    expect_out("stall.mcause", 0, 1, 12'h342, 32'h2, 1, 0, 32'h0);
    step(); expect_out("stall.mtval", 0, 1, 12'h343, 32'h0, 1, 0, 32'h0);
    step(); expect_out("stall.mstatus", 0, 1, 12'h300, 32'h1880, 1, 0, 32'h0);
    step(); MEM_WAIT = 1'b1; #1;
    expect_out("stall.jwait", 0, 0, 12'h0, 32'h0, 1, 0, 32'h0);
    MEM_WAIT = 1'b0; #1;
    expect_out("stall.jump", 0, 0, 12'h0, 32'h0, 1, 1, 32'h100);
    step(); expect_out("stall.idle", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);

    // Reset in T_MSTATUS, then a clean trap
    TRAP_EN = 1'b1;
    step(); TRAP_EN = 1'b0;
    step(); step(); step();
    expect_out("rmid.mstatus", 0, 1, 12'h300, 32'h1880, 1, 0, 32'h0);
    RST = 1'b1; MEM_WAIT = 1'b1;
    step(); RST = 1'b0; MEM_WAIT = 1'b0;
    expect_out("rmid.rst", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);
    step(); expect_out("rmid.after", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);
    TRAP_EN = 1'b1; TRAP_PC = 32'h4008; TRAP_CODE = 32'h5; TRAP_JMP_TO = 32'h180;
    step(); TRAP_EN = 1'b0;
    expect_out("re.mepc", 0, 1, 12'h341, 32'h4008, 1, 0, 32'h0);
    step(); expect_out("re.mcause", 0, 1, 12'h342, 32'h5, 1, 0, 32'h0);
    step(); step(); expect_out("re.mstatus", 0, 1, 12'h300, 32'h1880, 1, 0, 32'h0);
    step(); expect_out("re.jump", 0, 0, 12'h0, 32'h0, 1, 1, 32'h180);
    step(); expect_out("re.idle", 0, 0, 12'h0, 32'h0, 0, 0, 32'h0);

    // No mtval state; second request while busy is dropped
    RST = 1'b1; step(); RST = 1'b0;
    TRAP_EN = 1'b1; TRAP_PC = 32'h1006; TRAP_CODE = 32'h2; TRAP_JMP_TO = 32'h100;
    step();
    TRAP_PC = 32'h5000; TRAP_CODE = 32'h9; TRAP_JMP_TO = 32'h400;
    expect_out("nv.mepc", 1, 1, 12'h341, 32'h1004, 1, 0, 32'h0);
    step(); TRAP_EN = 1'b0;
    expect_out("nv.mcause", 1, 1, 12'h342, 32'h2, 1, 0, 32'h0);
    step(); expect_out("nv.mstatus", 1, 1, 12'h300, 32'h1880, 1, 0, 32'h0);
    step(); expect_out("nv.jump", 1, 0, 12'h0, 32'h0, 1, 1, 32'h100);
    step(); expect_out("nv.idle", 1, 0, 12'h0, 32'h0, 0, 0, 32'h0);
    step(); expect_out("nv.stay", 1, 0, 12'h0, 32'h0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
